controle_cifra: RTL and testbench

- Iterative AES encryption round sequencer.
- Holds the 128-bit state register and time-multiplexes one `substituiBytes` instance across all rounds, one round per clock.
- ShiftRows, MixColumns and AddRoundKey are implemented inline.
- Round keys come from an external key schedule/ROM through an index/key port.
- Sits between the block-input interface and the ciphertext consumer.

---
 rtl/controle_cifra_if.sv | 12 +
 rtl/controle_cifra.sv | 106 ++++++++++
 tb/tb_controle_cifra.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/controle_cifra_if.sv
// controle_cifra_if: block-in / key-lookup / ciphertext-out bundle of the AES round sequencer.
interface controle_cifra_if;
  logic         inicio;
  logic [127:0] bloco_entrada;
  logic [127:0] chave_rodada;
  logic [3:0]   indice_rodada;
  logic         ocupado;
  logic         pronto;
  logic [127:0] saida;
  modport master (output inicio, bloco_entrada, chave_rodada, input indice_rodada, ocupado, pronto, saida);
  modport slave  (input inicio, bloco_entrada, chave_rodada, output indice_rodada, ocupado, pronto, saida);
endinterface

// File: rtl/controle_cifra.sv
// controle_cifra: iterative AES encryption, one round per clock over a shared S-box bank.
module substituiBytes (
  input  logic [127:0] bloco,
  output logic [127:0] saida
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign saida[8*i +: 8] = SBOX[bloco[8*i +: 8]];
  end
endmodule

module controle_cifra #(
  parameter int NUM_RODADAS = 10
) (
  input logic clk,
  input logic rst,
  controle_cifra_if.slave bus
);
  typedef enum logic {OCIOSO, RODADA} fase_t;
  localparam logic [3:0] ULTIMA = 4'(NUM_RODADAS);
  fase_t        fase, fase_n;
  logic [3:0]   r, r_n;
  logic [127:0] estado, estado_n, saida_q, saida_n, sub, sr, mc;
  logic         pronto_q, pronto_n, ocupado_q, ocupado_n;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3, xtime(a1 ^ a2) ^ a0 ^ a2 ^ a3,
            xtime(a2 ^ a3) ^ a0 ^ a1 ^ a3, xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2};
  endfunction
  // byte k sits in row k%4, column k/4; row i rotates left by i columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++)
        o[127-8*(4*c+i) -: 8] = s[127-8*(4*((c+i)%4)+i) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction
  substituiBytes u_sub (.bloco(estado), .saida(sub));
  assign sr = shift_rows(sub);
  assign mc = mix_columns(sr);
  always_comb begin
    fase_n    = fase;
    r_n       = r;
    estado_n  = estado;
    saida_n   = saida_q;
    pronto_n  = 1'b0;
    ocupado_n = ocupado_q;
    if (fase == OCIOSO) begin
      if (bus.inicio) begin
        estado_n  = bus.bloco_entrada ^ bus.chave_rodada;
        r_n       = 4'd1;
        fase_n    = RODADA;
        ocupado_n = 1'b1;
      end
    end else if (r < ULTIMA) begin
      estado_n = mc ^ bus.chave_rodada;
      r_n      = r + 4'd1;
    end else begin
      saida_n   = sr ^ bus.chave_rodada;
      pronto_n  = 1'b1;
      ocupado_n = 1'b0;
      r_n       = 4'd0;
      fase_n    = OCIOSO;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fase      <= OCIOSO;
      r         <= 4'd0;
      estado    <= '0;
      saida_q   <= '0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      fase      <= fase_n;
      r         <= r_n;
      estado    <= estado_n;
      saida_q   <= saida_n;
      pronto_q  <= pronto_n;
      ocupado_q <= ocupado_n;
    end
  end
  assign bus.indice_rodada = (fase == RODADA) ? r : 4'd0;
  assign bus.saida         = saida_q;
  assign bus.pronto        = pronto_q;
  assign bus.ocupado       = ocupado_q;
endmodule

// File: tb/tb_controle_cifra.sv
// tb_controle_cifra: directed FIPS-197 vectors plus random blocks against a byte-level AES model.
module tb_controle_cifra;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0]   sb [256];
  logic [127:0] rk [0:10];
  logic [127:0] last = '0;
  controle_cifra_if bus ();
  controle_cifra #(.NUM_RODADAS(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.chave_rodada = (bus.indice_rodada <= 4'd10) ? rk[bus.indice_rodada] : '0;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box from first principles: multiplicative inverse then the affine map
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= 10; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask
  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] st;
    st = pt ^ rk[0];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int k = 0; k < 16; k++) s[k] = sb[st[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++) t[4*c+i] = s[4*((c+i)%4)+i];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++)
          s[4*c+i] = (rd < 10) ? gf_mul(t[4*c+i], 8'h02) ^ gf_mul(t[4*c+(i+1)%4], 8'h03)
                                 ^ t[4*c+(i+2)%4] ^ t[4*c+(i+3)%4] : t[4*c+i];
      for (int k = 0; k < 16; k++) st[127-8*k -: 8] = s[k];
      st ^= rk[rd];
    end
    return st;
  endfunction
  // starts at a negedge with the DUT idle; returns at the negedge where pronto is visible
  task automatic run(input logic [127:0] pt, input logic [127:0] exp, input bit poke, input bit hold);
    bus.inicio = 1'b1;
    bus.bloco_entrada = pt;
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("indice r%0d", k), 128'(bus.indice_rodada), 128'(k));
      chk($sformatf("ocupado r%0d", k), 128'(bus.ocupado), 128'(1));
      chk($sformatf("pronto r%0d", k), 128'(bus.pronto), 128'(0));
      chk($sformatf("saida hold r%0d", k), bus.saida, last);
      bus.inicio = hold || (poke && (k == 3 || k == 9));
      bus.bloco_entrada = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    chk("pronto done", 128'(bus.pronto), 128'(1));
    chk("ocupado done", 128'(bus.ocupado), 128'(0));
    chk("indice done", 128'(bus.indice_rodada), 128'(0));
    chk("saida done", bus.saida, exp);
    last = exp;
  endtask
  task automatic after_done();
    bus.inicio = 1'b0;
    @(negedge clk);
    chk("pronto single", 128'(bus.pronto), 128'(0));
  endtask
  initial begin
    logic [127:0] pt, key;
    bus.inicio = 1'b0;
    bus.bloco_entrada = '0;
    build_sbox();
    expand(K_B);
    #1;
    chk("rst ocupado", 128'(bus.ocupado), 128'(0));
    chk("rst pronto", 128'(bus.pronto), 128'(0));
    chk("rst saida", bus.saida, '0);
    chk("rst indice", 128'(bus.indice_rodada), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(PT_B, CT_B, 1'b0, 1'b0);
    after_done();
    run(PT_B, CT_B, 1'b1, 1'b0);
    after_done();
    expand(K_C);
    run(PT_C, CT_C, 1'b0, 1'b0);
    after_done();
    for (int i = 0; i < 20; i++) begin
      chk("idle saida", bus.saida, CT_C);
      chk("idle pronto", 128'(bus.pronto), 128'(0));
      chk("idle indice", 128'(bus.indice_rodada), 128'(0));
      @(negedge clk);
    end
    expand(K_B);
    run(PT_B, CT_B, 1'b0, 1'b1);
    expand(K_C);
    run(PT_C, CT_C, 1'b0, 1'b0);
    after_done();
    bus.inicio = 1'b1;
    bus.bloco_entrada = PT_C;
    @(negedge clk);
    bus.inicio = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-abort indice", 128'(bus.indice_rodada), 128'(5));
    #2 rst = 1'b1;
    #1;
    chk("abort ocupado", 128'(bus.ocupado), 128'(0));
    chk("abort pronto", 128'(bus.pronto), 128'(0));
    chk("abort saida", bus.saida, '0);
    chk("abort indice", 128'(bus.indice_rodada), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    last = '0;
    for (int i = 0; i < 15; i++) begin
      chk("abort no pronto", 128'(bus.pronto), 128'(0));
      @(negedge clk);
    end
    run(PT_C, CT_C, 1'b0, 1'b0);
    after_done();
    for (int n = 0; n < 6; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand(key);
      run(pt, aes_ref(pt), n[0], 1'b0);
      after_done();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
